// File: rtl/conv2d_engine.sv
// int8 2-D convolution engine: buffered input/filter load, one MAC term per
// cycle per output, accumulators streamed out over a valid/ready port.
module conv2d_engine #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 32,
  parameter int DIM_W     = 8,
  parameter int IN_DEPTH  = 1024,
  parameter int FLT_DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DIM_W-1:0]         in_h,
  input  logic [DIM_W-1:0]         in_w,
  input  logic [DIM_W-1:0]         in_c,
  input  logic [DIM_W-1:0]         k_h,
  input  logic [DIM_W-1:0]         k_w,
  input  logic [DIM_W-1:0]         out_c,
  input  logic [DIM_W-1:0]         out_h,
  input  logic [DIM_W-1:0]         out_w,
  input  logic [DIM_W-1:0]         stride_h,
  input  logic [DIM_W-1:0]         stride_w,
  input  logic [DIM_W-1:0]         pad_top,
  input  logic [DIM_W-1:0]         pad_left,
  input  logic [DATA_W-1:0]        input_zp,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  // state      | meaning
  // S_IDLE     | waiting for start; config latched and validated on start
  // S_LOAD_IN  | accepting input activations (NHWC)
  // S_LOAD_FLT | accepting filter weights (OHWI)
  // S_MAC      | issuing kh/kw/ic terms, last cycle drains the read pipe
  // S_EMIT     | presenting accumulator until the consumer takes it
  // S_DONE     | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_IN, S_LOAD_FLT, S_MAC, S_EMIT, S_DONE
  } state_t;

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int FLT_AW = $clog2(FLT_DEPTH);
  localparam int CW     = 2 * DIM_W + 2;
  localparam int PW     = 2 * DATA_W + 1;

  state_t state_q, state_d;

  logic [DIM_W-1:0] in_h_r, in_w_r, in_c_r, k_h_r, k_w_r, out_c_r, out_h_r, out_w_r;
  logic [DIM_W-1:0] stride_h_r, stride_w_r, pad_top_r, pad_left_r;
  logic signed [DATA_W-1:0] zp_r;
  logic err_q;

  logic [31:0] ld_rem, ld_ptr;
  logic [DIM_W-1:0] kh_q, kw_q, ic_q, oh_q, ow_q, oc_q;
  logic mac_drain;
  logic pipe_v;
  logic signed [ACC_W-1:0] acc_q;

  logic [DATA_W-1:0] in_buf  [IN_DEPTH];
  logic [DATA_W-1:0] flt_buf [FLT_DEPTH];
  logic signed [DATA_W-1:0] x_q, w_q;

  logic [31:0] in_vol_req, flt_vol_req, flt_vol;
  logic cfg_ok;
  logic ld_last, term_last, out_is_last, issue, in_range;
  logic signed [CW-1:0] ih, iw;
  logic [IN_AW-1:0]  in_addr;
  logic [FLT_AW-1:0] flt_addr;
  logic signed [DATA_W:0]   x_diff;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  term;

  assign in_vol_req  = 32'(in_h) * 32'(in_w) * 32'(in_c);
  assign flt_vol_req = 32'(k_h) * 32'(k_w) * 32'(in_c) * 32'(out_c);
  assign flt_vol     = 32'(k_h_r) * 32'(k_w_r) * 32'(in_c_r) * 32'(out_c_r);

  assign cfg_ok = (in_h != '0) && (in_w != '0) && (in_c != '0) &&
                  (k_h != '0) && (k_w != '0) && (out_c != '0) &&
                  (out_h != '0) && (out_w != '0) &&
                  (stride_h != '0) && (stride_w != '0) &&
                  (in_vol_req <= 32'(IN_DEPTH)) && (flt_vol_req <= 32'(FLT_DEPTH));

  assign ld_last     = (ld_rem == 32'd1);
  assign term_last   = (ic_q == in_c_r - DIM_W'(1)) && (kw_q == k_w_r - DIM_W'(1)) &&
                       (kh_q == k_h_r - DIM_W'(1));
  assign out_is_last = (oc_q == out_c_r - DIM_W'(1)) && (ow_q == out_w_r - DIM_W'(1)) &&
                       (oh_q == out_h_r - DIM_W'(1));
  assign issue       = (state_q == S_MAC) && !mac_drain;

  // Window coordinates may go negative under padding; keep them signed.
  assign ih = CW'(oh_q) * CW'(stride_h_r) + CW'(kh_q) - CW'(pad_top_r);
  assign iw = CW'(ow_q) * CW'(stride_w_r) + CW'(kw_q) - CW'(pad_left_r);
  assign in_range = !ih[CW-1] && (ih < $signed(CW'(in_h_r))) &&
                    !iw[CW-1] && (iw < $signed(CW'(in_w_r)));

  assign in_addr  = IN_AW'((32'(ih) * 32'(in_w_r) + 32'(iw)) * 32'(in_c_r) + 32'(ic_q));
  assign flt_addr = FLT_AW'(((32'(oc_q) * 32'(k_h_r) + 32'(kh_q)) * 32'(k_w_r) + 32'(kw_q))
                            * 32'(in_c_r) + 32'(ic_q));

  assign x_diff = {x_q[DATA_W-1], x_q} - {zp_r[DATA_W-1], zp_r};
  assign prod   = x_diff * w_q;
  assign term   = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign err    = err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ld_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:     if (start) state_d = cfg_ok ? S_LOAD_IN : S_DONE;
      S_LOAD_IN: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) state_d = S_LOAD_FLT;
      end
      S_LOAD_FLT: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) state_d = S_MAC;
      end
      S_MAC:      if (mac_drain) state_d = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        out_data  = acc_q;
        out_last  = out_is_last;
        if (out_ready) state_d = out_is_last ? S_DONE : S_MAC;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Buffers and their registered read ports carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD_IN && ld_valid)  in_buf[IN_AW'(ld_ptr)]   <= ld_data;
    if (state_q == S_LOAD_FLT && ld_valid) flt_buf[FLT_AW'(ld_ptr)] <= ld_data;
    x_q <= in_buf[in_addr];
    w_q <= flt_buf[flt_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_h_r <= '0; in_w_r <= '0; in_c_r <= '0; k_h_r <= '0; k_w_r <= '0;
      out_c_r <= '0; out_h_r <= '0; out_w_r <= '0;
      stride_h_r <= '0; stride_w_r <= '0; pad_top_r <= '0; pad_left_r <= '0;
      zp_r <= '0; err_q <= 1'b0;
      ld_rem <= '0; ld_ptr <= '0;
      kh_q <= '0; kw_q <= '0; ic_q <= '0; oh_q <= '0; ow_q <= '0; oc_q <= '0;
      mac_drain <= 1'b0; pipe_v <= 1'b0; acc_q <= '0;
    end else begin
      pipe_v <= issue && in_range;
      unique case (state_q)
        S_IDLE: if (start) begin
          in_h_r <= in_h; in_w_r <= in_w; in_c_r <= in_c; k_h_r <= k_h; k_w_r <= k_w;
          out_c_r <= out_c; out_h_r <= out_h; out_w_r <= out_w;
          stride_h_r <= stride_h; stride_w_r <= stride_w;
          pad_top_r <= pad_top; pad_left_r <= pad_left;
          zp_r <= input_zp; err_q <= !cfg_ok;
          ld_rem <= in_vol_req; ld_ptr <= '0;
          oh_q <= '0; ow_q <= '0; oc_q <= '0; acc_q <= '0;
        end
        S_LOAD_IN: if (ld_valid) begin
          ld_ptr <= ld_last ? '0 : ld_ptr + 32'd1;
          ld_rem <= ld_last ? flt_vol : ld_rem - 32'd1;
        end
        S_LOAD_FLT: if (ld_valid) begin
          ld_ptr <= ld_ptr + 32'd1;
          ld_rem <= ld_rem - 32'd1;
          kh_q <= '0; kw_q <= '0; ic_q <= '0;
          mac_drain <= 1'b0; acc_q <= '0;
        end
        S_MAC: begin
          if (pipe_v) acc_q <= acc_q + term;
          if (mac_drain) begin
            mac_drain <= 1'b0;
          end else begin
            if (term_last) mac_drain <= 1'b1;
            if (ic_q == in_c_r - DIM_W'(1)) begin
              ic_q <= '0;
              if (kw_q == k_w_r - DIM_W'(1)) begin
                kw_q <= '0;
                kh_q <= kh_q + DIM_W'(1);
              end else begin
                kw_q <= kw_q + DIM_W'(1);
              end
            end else begin
              ic_q <= ic_q + DIM_W'(1);
            end
          end
        end
        S_EMIT: if (out_ready) begin
          acc_q <= '0;
          kh_q <= '0; kw_q <= '0; ic_q <= '0;
          if (oc_q == out_c_r - DIM_W'(1)) begin
            oc_q <= '0;
            if (ow_q == out_w_r - DIM_W'(1)) begin
              ow_q <= '0;
              oh_q <= oh_q + DIM_W'(1);
            end else begin
              ow_q <= ow_q + DIM_W'(1);
            end
          end else begin
            oc_q <= oc_q + DIM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_engine.sv
// Self-checking bench for conv2d_engine: directed table of test-plan jobs,
// randomized jobs against a plain nested-loop convolution model, corner sequences.
module tb_conv2d_engine;

  logic        clk = 1'b0;
  logic        rst, start, ld_valid, ld_ready, out_valid, out_ready, out_last, busy, done, err;
  logic [7:0]  in_h, in_w, in_c, k_h, k_w, out_c, out_h, out_w;
  logic [7:0]  stride_h, stride_w, pad_top, pad_left, input_zp, ld_data;
  logic [31:0] out_data;

  int c_ih, c_iw, c_ic, c_kh, c_kw, c_oc, c_oh, c_ow, c_sh, c_sw, c_pt, c_pl, c_zp;
  assign in_h = c_ih[7:0];  assign in_w = c_iw[7:0];  assign in_c = c_ic[7:0];
  assign k_h = c_kh[7:0];   assign k_w = c_kw[7:0];   assign out_c = c_oc[7:0];
  assign out_h = c_oh[7:0]; assign out_w = c_ow[7:0];
  assign stride_h = c_sh[7:0]; assign stride_w = c_sw[7:0];
  assign pad_top = c_pt[7:0];  assign pad_left = c_pl[7:0];
  assign input_zp = c_zp[7:0];

  conv2d_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .in_h(in_h), .in_w(in_w), .in_c(in_c), .k_h(k_h), .k_w(k_w), .out_c(out_c),
    .out_h(out_h), .out_w(out_w), .stride_h(stride_h), .stride_w(stride_w),
    .pad_top(pad_top), .pad_left(pad_left), .input_zp(input_zp),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int x_arr [1024];
  int w_arr [1024];
  int exp_q [$];

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, want);
  endtask

  task automatic set_cfg(input int ih, iw, ic, kh, kw, oc, oh, ow, sh, sw, pt, pl, zp);
    c_ih = ih; c_iw = iw; c_ic = ic; c_kh = kh; c_kw = kw; c_oc = oc;
    c_oh = oh; c_ow = ow; c_sh = sh; c_sw = sw; c_pt = pt; c_pl = pl; c_zp = zp;
  endtask

  // Reference: direct definition of strided, padded convolution with zero-point.
  task automatic build_model();
    exp_q.delete();
    for (int oh = 0; oh < c_oh; oh++)
      for (int ow = 0; ow < c_ow; ow++)
        for (int oc = 0; oc < c_oc; oc++) begin
          int acc;
          acc = 0;
          for (int kh = 0; kh < c_kh; kh++)
            for (int kw = 0; kw < c_kw; kw++)
              for (int ic = 0; ic < c_ic; ic++) begin
                int yy, xx;
                yy = oh * c_sh + kh - c_pt;
                xx = ow * c_sw + kw - c_pl;
                if (yy >= 0 && yy < c_ih && xx >= 0 && xx < c_iw)
                  acc += (x_arr[(yy * c_iw + xx) * c_ic + ic] - c_zp) *
                         w_arr[((oc * c_kh + kh) * c_kw + kw) * c_ic + ic];
              end
          exp_q.push_back(acc);
        end
  endtask

  task automatic run_job(input int stall_first, input bit rnd);
    int in_vol, kvol, total, idx, cyc, got_n, mac_cnt, stall_left;
    longint hold_val;
    bit seen, stalled, fin;
    in_vol = c_ih * c_iw * c_ic;
    kvol   = c_kh * c_kw * c_ic;
    total  = in_vol + kvol * c_oc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ld_ready_after_start", ld_ready, 1);
    check("err_after_valid_start", err, 0);
    idx = 0; cyc = 0;
    while (idx < total && cyc < 20000) begin
      ld_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld_data  = (idx < in_vol) ? x_arr[idx][7:0] : w_arr[idx - in_vol][7:0];
      if (ld_valid && ld_ready) idx++;
      @(negedge clk); cyc++;
    end
    ld_valid = 1'b0;
    check("load_count", idx, total);
    got_n = 0; mac_cnt = 0; seen = 0; stalled = 0; fin = 0; cyc = 0;
    stall_left = stall_first; hold_val = 0;
    while (!fin && cyc < 20000) begin
      if (rnd) begin
        ld_valid = $urandom_range(0, 1);
        ld_data  = 8'($urandom);
      end
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", $signed(out_data), hold_val);
      end
      if (out_valid) begin
        if (!seen) begin
          check("mac_cycles", mac_cnt, kvol + 1);
          seen = 1;
        end
        hold_val = $signed(out_data);
        if (got_n == 0 && stall_left > 0) begin
          out_ready = 1'b0; stall_left--;
        end else begin
          out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        stalled = !out_ready;
        if (out_ready) begin
          check($sformatf("out_data[%0d]", got_n), $signed(out_data), exp_q[got_n]);
          check($sformatf("out_last[%0d]", got_n), out_last, got_n == exp_q.size() - 1);
          got_n++; seen = 0; mac_cnt = 0;
          if (got_n == exp_q.size()) fin = 1;
        end
      end else begin
        stalled = 0;
        out_ready = $urandom_range(0, 1);
        mac_cnt++;
      end
      @(negedge clk); cyc++;
    end
    out_ready = 1'b0; ld_valid = 1'b0;
    check("output_count", got_n, exp_q.size());
    check("done_pulse", done, 1);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("busy_cleared", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ld_ready"}, ld_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic random_job();
    set_cfg($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 4),
            $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
            $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 2),
            $urandom_range(1, 2), $urandom_range(0, 2), $urandom_range(0, 2),
            int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 1024; i++) begin
      x_arr[i] = int'($urandom_range(0, 255)) - 128;
      w_arr[i] = int'($urandom_range(0, 255)) - 128;
    end
    build_model();
    run_job(0, 1'b1);
  endtask

  typedef struct {
    int ih, iw, ic, kh, kw, oc, oh, ow, sh, sw, pt, pl, zp;
    int xmode, xval, wmode, wval, stall, eoff, n;
  } vec_t;

  vec_t vecs [6];
  int exp_tab [21];

  initial begin
    // xmode 1: raster index values; wmode 1: weight = index + 1
    vecs[0] = '{1,1,1, 1,1,1, 1,1, 1,1, 0,0, 0,    0,7,    0,-3,   0,  0,  1};
    vecs[1] = '{3,3,1, 3,3,1, 3,3, 1,1, 1,1, 0,    0,1,    0,1,    0,  1,  9};
    vecs[2] = '{4,4,1, 2,2,1, 2,2, 2,2, 0,0, 0,    1,0,    0,1,    0,  10, 4};
    vecs[3] = '{2,2,1, 1,1,1, 2,2, 1,1, 0,0, -128, 0,-128, 0,127,  0,  14, 4};
    vecs[4] = '{1,1,64,1,1,1, 1,1, 1,1, 0,0, -128, 0,127,  0,-128, 0,  18, 1};
    vecs[5] = '{1,1,1, 1,1,2, 1,1, 1,1, 0,0, 2,    0,5,    1,0,    10, 19, 2};
    exp_tab = '{-21, 4,6,4,6,9,6,4,6,4, 10,18,42,50, 0,0,0,0, -2088960, 3,6};

    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; out_ready = 1'b0;
    set_cfg(1,1,1, 1,1,1, 1,1, 1,1, 0,0, 0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      set_cfg(vecs[i].ih, vecs[i].iw, vecs[i].ic, vecs[i].kh, vecs[i].kw, vecs[i].oc,
              vecs[i].oh, vecs[i].ow, vecs[i].sh, vecs[i].sw, vecs[i].pt, vecs[i].pl,
              vecs[i].zp);
      for (int j = 0; j < 1024; j++) begin
        x_arr[j] = (vecs[i].xmode == 1) ? j : vecs[i].xval;
        w_arr[j] = (vecs[i].wmode == 1) ? j + 1 : vecs[i].wval;
      end
      exp_q.delete();
      for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(exp_tab[vecs[i].eoff + j]);
      run_job(vecs[i].stall, 1'b0);
    end

    // Rejected config: in_c = 0
    set_cfg(2,2,0, 1,1,1, 2,2, 1,1, 0,0, 0);
    @(negedge clk); start = 1'b1; ld_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    check("bad_cfg_done", done, 1);
    check("bad_cfg_err", err, 1);
    check("bad_cfg_ld_ready", ld_ready, 0);
    @(negedge clk); ld_valid = 1'b0;
    check("bad_cfg_idle", busy, 0);
    check("bad_cfg_err_held", err, 1);

    for (int i = 0; i < 6; i++) random_job();

    // Reset while loading filter weights, then a fresh job
    set_cfg(2,2,1, 1,1,2, 2,2, 1,1, 0,0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i + 1);
      @(negedge clk);
    end
    check("mid_flt_ld_ready", ld_ready, 1);
    rst = 1'b1; ld_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    random_job();
    random_job();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
